stack_alu_sequencer: RTL and testbench
======================================

// Module: stack_alu_sequencer
// PURPOSE
//  Front-end controller for the stack-based ALU datapath (push/pop/add/mul, 3-bit opcode).
//  Accepts an RPN instruction stream over a valid/ready handshake and issues one opcode at a time.
//  Tracks stack depth and rejects illegal, underflowing or overflowing instructions before issue.
//  Returns each result-producing op (add/mul/pop) with its overflow flag over a second valid/ready port.
// PARAMETERS
//  N      4    data width; must match the ALU's n
//  DEPTH  512  ALU stack entries; the depth counter spans 0..DEPTH
// PORTS
//  clk           in   1      single clock; ALU and sequencer both on posedge
//  rst_n         in   1      asynchronous, active-low reset
//  in_valid      in   1      instruction offered
//  in_ready      out  1      sequencer can accept
//  in_op         in   3      100 add, 101 mul, 110 push, 111 pop; any other value is illegal
//  in_data       in   N      push operand (signed)
//  alu_opcode    out  3      to ALU opcode; 000 (ALU no-op) when not issuing
//  alu_data      out  N      to ALU input_data
//  alu_result    in   N      from ALU output_data
//  alu_overflow  in   1      from ALU overflow
//  res_valid     out  1      result held
//  res_ready     in   1      consumer takes result
//  res_data      out  N      captured alu_result
//  res_ovf       out  1      captured alu_overflow
//  err           out  1      one-cycle pulse on a rejected instruction
//  err_code      out  2      01 underflow, 10 full, 11 illegal op; holds until next err
//  depth         out  clog2(DEPTH+1)  current stack occupancy
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; alu_opcode=000; depth=0.
//  FSM states: IDLE -> ISSUE -> (IDLE | WAIT -> RESP -> IDLE).
//  IDLE: in_ready=1. Accept when in_valid&&in_ready. Check in this priority:
//   illegal op -> err 11; push with depth==DEPTH -> err 10;
//   add/mul with depth<2 -> err 01; pop with depth<2 -> err 01 (ALU never pops its bottom entry).
//   A rejected instruction raises err for the next cycle, is not issued, and leaves the FSM in IDLE.
//  ISSUE (1 cycle): alu_opcode=in_op (registered) and alu_data=in_data; in_ready=0.
//   The ALU samples both at the end of ISSUE.
//   push: depth+1, next IDLE. pop: depth-1. add/mul: depth unchanged (operands not consumed).
//  WAIT (1 cycle): alu_opcode=000. Capture alu_result/alu_overflow into res_data/res_ovf at the end of WAIT.
//  RESP: res_valid=1, data stable, until res_ready; then res_valid=0 and next IDLE.
//  Latency: push accept at edge T -> in_ready high again at T+2.
//   add/mul/pop accept at T -> res_valid high from T+3.
//  Only one instruction in flight; in_ready=0 in ISSUE/WAIT/RESP.
//  res_ready while res_valid=0 is ignored.
//  Reset mid-op: abort and clear depth. The ALU has no reset, so the bench resets both together.
//  Depth arithmetic saturates by construction: guards forbid wrap below 0 or above DEPTH.
// CONFIGURATION
//  STACK_SEQ_STATS_EN defined: adds outputs n_issued[15:0], n_errors[15:0], n_ovf[15:0].
//   All three reset to 0 and wrap at 2^16.
//   n_issued increments per ISSUE; n_errors per err pulse; n_ovf per RESP entry with res_ovf=1.
//  Not defined: these ports and counters do not exist; behaviour is otherwise identical.
// STRUCTURE
//  Shared package stack_alu_pkg:
//   opcode localparams OP_ADD=3'b100, OP_MUL=3'b101, OP_PUSH=3'b110, OP_POP=3'b111, OP_NOP=3'b000;
//   err-code localparams ERR_UFL, ERR_FULL, ERR_ILL; FSM state encoding.
//  One sub-module: stack_seq_depth_ctr.
//   Inputs inc/dec; output depth plus flags full, lt2.
//  The FSM and result capture stay in the top module; the ALU instance sits in the bench/top.
// TESTING (N=4, DEPTH=512, sequencer driving a real ALU instance)
//  Push 3, push 2, add
//   -> res_data=5, res_ovf=0, depth=2, res_valid 3 cycles after accept.
//  Push 7, push 1, add
//   -> res_data=-8 (4'b1000), res_ovf=1.
//  Push 3, push 3, mul
//   -> res_data=9 (4'b1001), res_ovf=1; then pop -> res_data=3, depth=1.
//  From reset: add -> err=1, err_code=01, no ALU opcode issued.
//   Then op 3'b010 -> err_code=11. Then pop at depth 1 -> err_code=01.
//  512 pushes, then a 513th push -> err_code=10, depth stays 512.
//  Hold res_ready=0 for 5 cycles -> res_valid and res_data stable, in_ready=0.
//   Assert rst_n=0 mid-RESP -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/stack_alu_pkg.sv
// Shared constants for the stack ALU front-end: opcodes, error codes and sequencer state encoding.
package stack_alu_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_UFL  = 2'b01;
  localparam logic [1:0] ERR_FULL = 2'b10;
  localparam logic [1:0] ERR_ILL  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Every legal opcode has the MSB set; 0xx values are reserved.
  function automatic logic op_is_legal(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/stack_seq_depth_ctr.sv
// Stack occupancy counter mirroring the ALU stack; flags drive the sequencer's issue guards.
module stack_seq_depth_ctr #(
  parameter int DEPTH = 512,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          lt2
);

  logic [DW-1:0] depth_q, depth_d;

  always_comb begin
    depth_d = depth_q;
    if (inc && !dec && !full)
      depth_d = depth_q + DW'(1);
    else if (dec && !inc && (depth_q != '0))
      depth_d = depth_q - DW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) depth_q <= '0;
    else        depth_q <= depth_d;
  end

  assign depth = depth_q;
  assign full  = (depth_q == DW'(DEPTH));
  assign lt2   = (depth_q < DW'(2));

endmodule

// File: rtl/stack_alu_sequencer.sv
// RPN instruction front-end for the stack ALU: guards, issues one op at a time, returns results.
// Optional statistics counters are built when STACK_SEQ_STATS_EN is defined.
module stack_alu_sequencer
  import stack_alu_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 512,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [N-1:0]  in_data,
  output logic [2:0]    alu_opcode,
  output logic [N-1:0]  alu_data,
  input  logic [N-1:0]  alu_result,
  input  logic          alu_overflow,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [N-1:0]  res_data,
  output logic          res_ovf,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [DW-1:0] depth
`ifdef STACK_SEQ_STATS_EN
  ,
  output logic [15:0]   n_issued,
  output logic [15:0]   n_errors,
  output logic [15:0]   n_ovf
`endif
);

  logic [1:0]   state_q, state_d;
  logic         in_ready_q;
  logic [2:0]   alu_opcode_q;
  logic [N-1:0] alu_data_q;
  logic         res_valid_q;
  logic [N-1:0] res_data_q;
  logic         res_ovf_q;
  logic         err_q;
  logic [1:0]   err_code_q;

  logic         accept, issue_ok, reject;
  logic [1:0]   rej_code;
  logic         full, lt2, inc, dec;

  // in_ready is registered so it reads 0 while reset is asserted.
  assign accept = in_valid && in_ready_q;

  always_comb begin
    rej_code = ERR_NONE;
    if (!op_is_legal(in_op))
      rej_code = ERR_ILL;
    else if (in_op == OP_PUSH) begin
      if (full) rej_code = ERR_FULL;
    end else if (lt2)
      rej_code = ERR_UFL;
  end

  assign issue_ok = accept && (rej_code == ERR_NONE);
  assign reject   = accept && (rej_code != ERR_NONE);

  assign inc = (state_q == ST_ISSUE) && (alu_opcode_q == OP_PUSH);
  assign dec = (state_q == ST_ISSUE) && (alu_opcode_q == OP_POP);

  stack_seq_depth_ctr #(.DEPTH(DEPTH)) u_depth (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc),
    .dec   (dec),
    .depth (depth),
    .full  (full),
    .lt2   (lt2)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (issue_ok) state_d = ST_ISSUE;
      ST_ISSUE: state_d = (alu_opcode_q == OP_PUSH) ? ST_IDLE : ST_WAIT;
      ST_WAIT:  state_d = ST_RESP;
      ST_RESP:  if (res_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b0;
      alu_opcode_q <= OP_NOP;
      alu_data_q   <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_ovf_q    <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= (state_d == ST_IDLE);
      alu_opcode_q <= issue_ok ? in_op : OP_NOP;
      if (issue_ok) alu_data_q <= in_data;
      res_valid_q  <= (state_d == ST_RESP);
      if (state_q == ST_WAIT) begin
        res_data_q <= alu_result;
        res_ovf_q  <= alu_overflow;
      end
      err_q <= reject;
      if (reject) err_code_q <= rej_code;
    end
  end

`ifdef STACK_SEQ_STATS_EN
  logic [15:0] n_issued_q, n_errors_q, n_ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_issued_q <= '0;
      n_errors_q <= '0;
      n_ovf_q    <= '0;
    end else begin
      if (state_q == ST_ISSUE) n_issued_q <= n_issued_q + 16'd1;
      if (reject)              n_errors_q <= n_errors_q + 16'd1;
      if ((state_q == ST_WAIT) && alu_overflow) n_ovf_q <= n_ovf_q + 16'd1;
    end
  end

  assign n_issued = n_issued_q;
  assign n_errors = n_errors_q;
  assign n_ovf    = n_ovf_q;
`endif

  assign in_ready   = in_ready_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_data   = alu_data_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_ovf    = res_ovf_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Directed bench for stack_alu_sequencer driving a behavioural 4-bit stack ALU.
module tb_stack_alu_sequencer;

  localparam int N     = 4;
  localparam int DEPTH = 512;
  localparam int DW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = 3'b000;
  logic [N-1:0]  in_data = '0;
  logic [2:0]    alu_opcode;
  logic [N-1:0]  alu_data;
  logic [N-1:0]  alu_result;
  logic          alu_overflow;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [N-1:0]  res_data;
  logic          res_ovf;
  logic          err;
  logic [1:0]    err_code;
  logic [DW-1:0] depth;
`ifdef STACK_SEQ_STATS_EN
  logic [15:0]   n_issued, n_errors, n_ovf;
`endif

  always #5 clk = ~clk;

  stack_alu_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_data      (in_data),
    .alu_opcode   (alu_opcode),
    .alu_data     (alu_data),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_ovf      (res_ovf),
    .err          (err),
    .err_code     (err_code),
    .depth        (depth)
`ifdef STACK_SEQ_STATS_EN
    ,
    .n_issued     (n_issued),
    .n_errors     (n_errors),
    .n_ovf        (n_ovf)
`endif
  );

  // Behavioural stack ALU: samples opcode/data at each posedge, result valid the following cycle.
  logic signed [N-1:0] alu_mem [0:DEPTH-1];
  int alu_sp;
  int alu_s;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_sp       <= 0;
      alu_result   <= '0;
      alu_overflow <= 1'b0;
    end else begin
      case (alu_opcode)
        3'b110: if (alu_sp < DEPTH) begin
          alu_mem[alu_sp] <= alu_data;
          alu_sp <= alu_sp + 1;
        end
        3'b100, 3'b101: if (alu_sp >= 2) begin
          if (alu_opcode == 3'b100)
            alu_s = int'(alu_mem[alu_sp-1]) + int'(alu_mem[alu_sp-2]);
          else
            alu_s = int'(alu_mem[alu_sp-1]) * int'(alu_mem[alu_sp-2]);
          alu_result   <= 4'(alu_s);
          alu_overflow <= (alu_s > 7) || (alu_s < -8);
        end
        3'b111: if (alu_sp >= 1) begin
          alu_result   <= alu_mem[alu_sp-1];
          alu_overflow <= 1'b0;
          alu_sp       <= alu_sp - 1;
        end
        default: ;
      endcase
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] data);
    wait_ready();
    in_valid = 1'b1;
    in_op    = op;
    in_data  = data;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] op;
    logic [3:0] data;
    logic       rej;
    logic [1:0] code;
    logic [3:0] res;
    logic       ovf;
    int         dep;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int n;
    if (v.rst) do_reset();
    send(v.op, v.data);
    // Now one negedge after the accepting edge.
    if (v.rej) begin
      chk("err_pulse", 32'(err), 32'd1);
      chk("err_code", 32'(err_code), 32'(v.code));
      chk("no_issue", 32'(alu_opcode), 32'd0);
      @(negedge clk);
      chk("err_clear", 32'(err), 32'd0);
      chk("depth_rej", 32'(depth), 32'(v.dep));
    end else if (v.op == 3'b110) begin
      chk("issue_op", 32'(alu_opcode), 32'(v.op));
      chk("issue_data", 32'(alu_data), 32'(v.data));
      chk("ready_low_issue", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("push_ready_back", 32'(in_ready), 32'd1);
      chk("depth_push", 32'(depth), 32'(v.dep));
      chk("err_code_hold", 32'(err_code), 32'(v.code));
    end else begin
      chk("issue_op", 32'(alu_opcode), 32'(v.op));
      n = 1;
      while (!res_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("res_latency", 32'(n), 32'd3);
      chk("res_data", 32'(res_data), 32'(v.res));
      chk("res_ovf", 32'(res_ovf), 32'(v.ovf));
      chk("depth_res", 32'(depth), 32'(v.dep));
      chk("err_code_hold", 32'(err_code), 32'(v.code));
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      chk("res_valid_drop", 32'(res_valid), 32'd0);
    end
  endtask

  vec_t vecs[18];

  initial begin
    //                rst  op      data    rej   code   res     ovf   dep
    vecs[0]  = '{1'b1, 3'b100, 4'h0, 1'b1, 2'b01, 4'h0, 1'b0, 0};
    vecs[1]  = '{1'b0, 3'b010, 4'h0, 1'b1, 2'b11, 4'h0, 1'b0, 0};
    vecs[2]  = '{1'b0, 3'b110, 4'h3, 1'b0, 2'b11, 4'h0, 1'b0, 1};
    vecs[3]  = '{1'b0, 3'b111, 4'h0, 1'b1, 2'b01, 4'h0, 1'b0, 1};
    vecs[4]  = '{1'b0, 3'b110, 4'h2, 1'b0, 2'b01, 4'h0, 1'b0, 2};
    vecs[5]  = '{1'b0, 3'b100, 4'h0, 1'b0, 2'b01, 4'h5, 1'b0, 2};
    vecs[6]  = '{1'b1, 3'b110, 4'h7, 1'b0, 2'b00, 4'h0, 1'b0, 1};
    vecs[7]  = '{1'b0, 3'b110, 4'h1, 1'b0, 2'b00, 4'h0, 1'b0, 2};
    vecs[8]  = '{1'b0, 3'b100, 4'h0, 1'b0, 2'b00, 4'h8, 1'b1, 2};
    vecs[9]  = '{1'b1, 3'b110, 4'h3, 1'b0, 2'b00, 4'h0, 1'b0, 1};
    vecs[10] = '{1'b0, 3'b110, 4'h3, 1'b0, 2'b00, 4'h0, 1'b0, 2};
    vecs[11] = '{1'b0, 3'b101, 4'h0, 1'b0, 2'b00, 4'h9, 1'b1, 2};
    vecs[12] = '{1'b0, 3'b111, 4'h0, 1'b0, 2'b00, 4'h3, 1'b0, 1};
    vecs[13] = '{1'b0, 3'b110, 4'hE, 1'b0, 2'b00, 4'h0, 1'b0, 2};
    vecs[14] = '{1'b0, 3'b101, 4'h0, 1'b0, 2'b00, 4'hA, 1'b0, 2};
    vecs[15] = '{1'b0, 3'b000, 4'h0, 1'b1, 2'b11, 4'h0, 1'b0, 2};
    vecs[16] = '{1'b0, 3'b011, 4'h0, 1'b1, 2'b11, 4'h0, 1'b0, 2};
    vecs[17] = '{1'b0, 3'b111, 4'h0, 1'b0, 2'b11, 4'hE, 1'b0, 1};

    do_reset();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_opcode", 32'(alu_opcode), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);

    for (int i = 0; i < 18; i++) run_vec(vecs[i]);

    // Fill the stack, then overflow it.
    do_reset();
    for (int i = 0; i < DEPTH; i++) send(3'b110, 4'(i));
    wait_ready();
    chk("depth_full", 32'(depth), 32'(DEPTH));
    run_vec('{1'b0, 3'b110, 4'h1, 1'b1, 2'b10, 4'h0, 1'b0, DEPTH});
    // Top two entries are 4'hF (-1) and 4'hE (-2).
    run_vec('{1'b0, 3'b100, 4'h0, 1'b0, 2'b10, 4'hD, 1'b0, DEPTH});
`ifdef STACK_SEQ_STATS_EN
    chk("n_issued", 32'(n_issued), 32'(DEPTH + 1));
    chk("n_errors", 32'(n_errors), 32'd1);
`endif

    // Back-pressured result, then asynchronous reset during RESP.
    do_reset();
    run_vec('{1'b0, 3'b010, 4'h0, 1'b1, 2'b11, 4'h0, 1'b0, 0});
    run_vec('{1'b0, 3'b110, 4'h5, 1'b0, 2'b11, 4'h0, 1'b0, 1});
    run_vec('{1'b0, 3'b110, 4'h1, 1'b0, 2'b11, 4'h0, 1'b0, 2});
    send(3'b100, 4'h0);
    begin
      int n = 0;
      while (!res_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_data", 32'(res_data), 32'd6);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_opcode", 32'(alu_opcode), 32'd0);
    chk("arst_alu_data", 32'(alu_data), 32'd0);
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    chk("arst_res_data", 32'(res_data), 32'd0);
    chk("arst_res_ovf", 32'(res_ovf), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_err_code", 32'(err_code), 32'd0);
    chk("arst_depth", 32'(depth), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec('{1'b0, 3'b111, 4'h0, 1'b1, 2'b01, 4'h0, 1'b0, 0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
